// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the control-word sequencer: opcodes, word field
// positions and the sequencing state encoding.
package ctrl_seq_pkg;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int REP_MSB = 11;
   localparam int REP_LSB = 8;
   localparam int ARG_MSB = 7;
   localparam int ARG_LSB = 0;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_RUN   = 4'd1;
   localparam logic [3:0] OP_HALT  = 4'd2;
   localparam logic [3:0] OP_CLEAR = 4'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_DONE,
      ST_GAP
   } state_e;

endpackage

// File: rtl/ctrl_seq_timer.sv
// Loadable down-counter shared by the inter-run gap and the completion
// timeout; expired_o is high whenever the count has reached zero.
module ctrl_seq_timer
   import ctrl_seq_pkg::*;
#(
   parameter int CW = 11
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   output logic          expired_o
);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ctrl_cmd_sequencer.sv
// Decodes control words and sequences a datapath through dp_start/dp_done,
// with repeat gaps, a one-entry pending slot, completion timeout and sticky errors.
module ctrl_cmd_sequencer
   import ctrl_seq_pkg::*;
#(
   parameter int ARG_W          = 8,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic             ACLK,
   input  logic             ARESETN,
   input  logic [31:0]      control_reg,
   input  logic             control_valid,
   output logic             control_read,
   output logic             dp_start,
   output logic [ARG_W-1:0] dp_arg,
   input  logic             dp_done,
   output logic             dp_abort,
   output logic             busy,
   output logic             pending_full,
   output logic             err_timeout,
   output logic             err_opcode,
   output logic [CNT_W-1:0] done_count
);

   localparam int TMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int REPW = REP_MSB - REP_LSB + 1;

   state_e           state_q;
   logic             control_read_q, dp_start_q, dp_abort_q;
   logic             err_timeout_q, err_opcode_q, pend_vld_q;
   logic [CNT_W-1:0] done_count_q;
   logic [ARG_W-1:0] arg_q, pend_arg_q;
   logic [REPW-1:0]  rem_q, pend_rep_q;

   logic [3:0]       opc;
   logic [REPW-1:0]  word_rep;
   logic [ARG_W-1:0] word_arg;
   logic             unused_hi;

   assign opc       = control_reg[OPC_MSB:OPC_LSB];
   assign word_rep  = control_reg[REP_MSB:REP_LSB];
   assign word_arg  = control_reg[ARG_LSB +: ARG_W];
   assign unused_hi = ^control_reg[31:16];

   logic run_ok, accept, acc_run, acc_halt, acc_clear, acc_ill;
   logic in_wait, done_ev, last_done, timeout_ev, finish;
   logic tmr_load, tmr_exp;
   logic [TW-1:0] tmr_val;

   // A RUN is refused only while a command is active and the pending slot is occupied.
   assign run_ok     = (state_q == ST_IDLE) || !pend_vld_q;
   assign accept     = control_valid && !control_read_q && ((opc != OP_RUN) || run_ok);
   assign acc_run    = accept && (opc == OP_RUN);
   assign acc_halt   = accept && (opc == OP_HALT);
   assign acc_clear  = accept && (opc == OP_CLEAR);
   assign acc_ill    = accept && (opc > OP_CLEAR);

   assign in_wait    = (state_q == ST_WAIT_DONE);
   assign done_ev    = in_wait && dp_done && !acc_halt;
   assign last_done  = done_ev && (rem_q == '0);
   assign timeout_ev = in_wait && !dp_done && tmr_exp && !acc_halt;
   assign finish     = last_done || timeout_ev;

   assign tmr_load   = (state_q == ST_ISSUE) || (done_ev && (rem_q != '0));
   assign tmr_val    = (state_q == ST_ISSUE) ? TW'(TIMEOUT_CYCLES - 1) : TW'(GAP_CYCLES - 1);

   ctrl_seq_timer #(
      .CW(TW)
   ) u_timer (
      .clk_i      (ACLK),
      .rst_i      (ARESETN),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .expired_o  (tmr_exp)
   );

   always_ff @(posedge ACLK) begin
      if (acc_run && state_q != ST_IDLE && !pend_vld_q) begin
         pend_arg_q <= word_arg;
         pend_rep_q <= word_rep;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESETN) begin
         state_q        <= ST_IDLE;
         control_read_q <= 1'b0;
         dp_start_q     <= 1'b0;
         dp_abort_q     <= 1'b0;
         err_timeout_q  <= 1'b0;
         err_opcode_q   <= 1'b0;
         pend_vld_q     <= 1'b0;
         done_count_q   <= '0;
         arg_q          <= '0;
         rem_q          <= '0;
      end else begin
         control_read_q <= accept;
         dp_start_q     <= 1'b0;
         dp_abort_q     <= 1'b0;

         if (acc_clear)    err_opcode_q <= 1'b0;
         else if (acc_ill) err_opcode_q <= 1'b1;

         if (timeout_ev)     err_timeout_q <= 1'b1;
         else if (acc_clear) err_timeout_q <= 1'b0;

         if (acc_clear)      done_count_q <= '0;
         else if (last_done) done_count_q <= done_count_q + 1'b1;

         if (acc_run && state_q != ST_IDLE) pend_vld_q <= 1'b1;

         if (acc_halt) begin
            pend_vld_q <= 1'b0;
            state_q    <= ST_IDLE;
            dp_abort_q <= (state_q == ST_ISSUE) || (state_q == ST_WAIT_DONE);
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (acc_run) begin
                     arg_q      <= word_arg;
                     rem_q      <= word_rep;
                     dp_start_q <= 1'b1;
                     state_q    <= ST_ISSUE;
                  end
               end
               ST_ISSUE: state_q <= ST_WAIT_DONE;
               ST_WAIT_DONE: begin
                  if (done_ev && rem_q != '0) begin
                     rem_q   <= rem_q - 1'b1;
                     state_q <= ST_GAP;
                  end else if (finish) begin
                     dp_abort_q <= timeout_ev;
                     // Next command: the pending slot first, else a RUN arriving this very cycle.
                     if (pend_vld_q) begin
                        arg_q      <= pend_arg_q;
                        rem_q      <= pend_rep_q;
                        pend_vld_q <= 1'b0;
                        dp_start_q <= 1'b1;
                        state_q    <= ST_ISSUE;
                     end else if (acc_run) begin
                        arg_q      <= word_arg;
                        rem_q      <= word_rep;
                        pend_vld_q <= 1'b0;
                        dp_start_q <= 1'b1;
                        state_q    <= ST_ISSUE;
                     end else begin
                        state_q <= ST_IDLE;
                     end
                  end
               end
               ST_GAP: begin
                  if (tmr_exp) begin
                     dp_start_q <= 1'b1;
                     state_q    <= ST_ISSUE;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign control_read = control_read_q;
   assign dp_start     = dp_start_q;
   assign dp_arg       = arg_q;
   assign dp_abort     = dp_abort_q;
   assign busy         = (state_q != ST_IDLE) || pend_vld_q;
   assign pending_full = pend_vld_q;
   assign err_timeout  = err_timeout_q;
   assign err_opcode   = err_opcode_q;
   assign done_count   = done_count_q;

endmodule

// File: tb/tb_ctrl_cmd_sequencer.sv
// Scoreboard bench for ctrl_cmd_sequencer: stimulus queues expected dp_start
// args and dp_abort pulses, a monitor pops them as the DUT presents them.
module tb_ctrl_cmd_sequencer;

   localparam int ARG_W = 8;
   localparam int GAP   = 4;
   localparam int TO    = 16;
   localparam int CNT_W = 16;

   logic             ACLK = 1'b0;
   logic             ARESETN = 1'b1;
   logic [31:0]      control_reg = '0;
   logic             control_valid = 1'b0;
   logic             control_read;
   logic             dp_start;
   logic [ARG_W-1:0] dp_arg;
   logic             dp_done;
   logic             dp_abort;
   logic             busy;
   logic             pending_full;
   logic             err_timeout;
   logic             err_opcode;
   logic [CNT_W-1:0] done_count;

   logic dp_done_auto = 1'b0;
   logic dp_done_man  = 1'b0;
   logic auto_done    = 1'b0;
   int   done_lat     = 3;
   assign dp_done = dp_done_auto | dp_done_man;

   always #5 ACLK = ~ACLK;

   ctrl_cmd_sequencer #(
      .ARG_W(ARG_W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .control_reg(control_reg),
      .control_valid(control_valid), .control_read(control_read),
      .dp_start(dp_start), .dp_arg(dp_arg), .dp_done(dp_done),
      .dp_abort(dp_abort), .busy(busy), .pending_full(pending_full),
      .err_timeout(err_timeout), .err_opcode(err_opcode), .done_count(done_count)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   logic [ARG_W-1:0] q_start[$];
   int q_abort[$];
   int start_cycs[$];
   int abort_cycs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge ACLK);
      cyc++;
   end

   // Datapath model: pulses dp_done done_lat cycles after each dp_start when enabled.
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge ACLK);
         #1;
         dp_done_auto = 1'b0;
         if (ARESETN) cnt = 0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) dp_done_auto = 1'b1;
         end
         if (auto_done && dp_start) cnt = done_lat;
      end
   end

   // Monitor: every dp_start / dp_abort must match the head of its queue.
   initial forever begin
      @(negedge ACLK);
      if (dp_start) begin
         start_cycs.push_back(cyc);
         if (q_start.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL dp_start: unexpected pulse with arg 0x%0h, none expected (cycle %0d)", dp_arg, cyc);
         end else begin
            chk("dp_start_arg", 32'(dp_arg), 32'(q_start.pop_front()));
         end
      end
      if (dp_abort) begin
         abort_cycs.push_back(cyc);
         n_cmp++;
         if (q_abort.size() == 0) begin
            n_fail++;
            $display("FAIL dp_abort: unexpected pulse, none expected (cycle %0d)", cyc);
         end else begin
            void'(q_abort.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic offer(input logic [31:0] w);
      tick();
      control_reg   = w;
      control_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (control_read) break;
      end
      chk("control_read_on_accept", 32'(control_read), 32'd1);
      control_valid = 1'b0;
   endtask

   task automatic send(input logic [31:0] w);
      offer(w);
      tick();
      chk("control_read_single_pulse", 32'(control_read), 32'd0);
   endtask

   task automatic wait_idle(input int bound);
      int k;
      k = 0;
      while (busy && k < bound) begin
         tick();
         k++;
      end
      chk("busy_drops_within_bound", 32'(busy), 32'd0);
      tick();
      tick();
   endtask

   task automatic chk_outputs_zero();
      chk("rst_control_read", 32'(control_read), 32'd0);
      chk("rst_dp_start",     32'(dp_start),     32'd0);
      chk("rst_dp_arg",       32'(dp_arg),       32'd0);
      chk("rst_dp_abort",     32'(dp_abort),     32'd0);
      chk("rst_busy",         32'(busy),         32'd0);
      chk("rst_pending_full", 32'(pending_full), 32'd0);
      chk("rst_err_timeout",  32'(err_timeout),  32'd0);
      chk("rst_err_opcode",   32'(err_opcode),   32'd0);
      chk("rst_done_count",   32'(done_count),   32'd0);
   endtask

   initial begin
      int i0;
      int mg;

      repeat (3) tick();
      chk_outputs_zero();
      ARESETN = 1'b0;
      tick();

      // Three runs of arg 5, done 3 cycles after each start.
      auto_done = 1'b1;
      done_lat  = 3;
      i0 = start_cycs.size();
      repeat (3) q_start.push_back(8'h05);
      send(32'h0000_1205);
      wait_idle(200);
      chk("t1_start_count", 32'(start_cycs.size() - i0), 32'd3);
      mg = 1000000;
      for (int i = i0 + 1; i < start_cycs.size(); i++)
         if (start_cycs[i] - start_cycs[i-1] < mg) mg = start_cycs[i] - start_cycs[i-1];
      chk("t1_start_spacing_ge_gap_plus_2", 32'(mg >= GAP + 2), 32'd1);
      chk("t1_done_count", 32'(done_count), 32'd1);

      // Pending slot and backpressure.
      send(32'h0000_3000);
      chk("t2_clear_done_count", 32'(done_count), 32'd0);
      done_lat = 10;
      q_start.push_back(8'h07);
      q_start.push_back(8'h09);
      q_start.push_back(8'h0A);
      send(32'h0000_1007);
      send(32'h0000_1009);
      chk("t2_pending_full_after_2nd", 32'(pending_full), 32'd1);
      tick();
      control_reg   = 32'h0000_100A;
      control_valid = 1'b1;
      tick();
      tick();
      chk("t2_held_control_read", 32'(control_read), 32'd0);
      chk("t2_held_pending_full", 32'(pending_full), 32'd1);
      for (int i = 0; i < 100; i++) begin
         tick();
         if (control_read) break;
      end
      chk("t2_held_word_taken", 32'(control_read), 32'd1);
      control_valid = 1'b0;
      wait_idle(300);
      chk("t2_done_count", 32'(done_count), 32'd3);

      // Completion timeout, then CLEAR.
      auto_done = 1'b0;
      send(32'h0000_3000);
      chk("t3_clear_done_count", 32'(done_count), 32'd0);
      q_start.push_back(8'h01);
      q_abort.push_back(1);
      offer(32'h0000_1001);
      wait_idle(TO + 40);
      chk("t3_abort_latency", 32'(abort_cycs[$] - start_cycs[$]), 32'(TO + 1));
      chk("t3_err_timeout", 32'(err_timeout), 32'd1);
      chk("t3_done_count", 32'(done_count), 32'd0);
      send(32'h0000_3000);
      chk("t3_err_timeout_cleared", 32'(err_timeout), 32'd0);

      // HALT during WAIT_DONE with pending loaded.
      q_start.push_back(8'h02);
      send(32'h0000_1F02);
      send(32'h0000_1003);
      chk("t4_pending_full", 32'(pending_full), 32'd1);
      q_abort.push_back(1);
      send(32'h0000_2000);
      chk("t4_pending_cleared", 32'(pending_full), 32'd0);
      chk("t4_busy_after_halt", 32'(busy), 32'd0);
      repeat (30) tick();
      chk("t4_done_count", 32'(done_count), 32'd0);

      // HALT accepted together with dp_done: no count.
      auto_done = 1'b1;
      done_lat  = 2;
      q_start.push_back(8'h04);
      send(32'h0000_1004);
      wait_idle(100);
      chk("t5_done_count_base", 32'(done_count), 32'd1);
      auto_done = 1'b0;
      q_start.push_back(8'h00);
      offer(32'h0000_1000);
      tick();
      q_abort.push_back(1);
      control_reg   = 32'h0000_2000;
      control_valid = 1'b1;
      dp_done_man   = 1'b1;
      tick();
      dp_done_man   = 1'b0;
      control_valid = 1'b0;
      chk("t5_halt_taken", 32'(control_read), 32'd1);
      tick();
      chk("t5_halt_wins_count", 32'(done_count), 32'd1);
      chk("t5_halt_idle", 32'(busy), 32'd0);

      // dp_done on exactly the timeout cycle: counted, no error.
      q_start.push_back(8'h06);
      offer(32'h0000_1006);
      repeat (TO) tick();
      dp_done_man = 1'b1;
      tick();
      dp_done_man = 1'b0;
      tick();
      chk("t5_done_on_timeout_err", 32'(err_timeout), 32'd0);
      chk("t5_done_on_timeout_count", 32'(done_count), 32'd2);
      chk("t5_done_on_timeout_idle", 32'(busy), 32'd0);

      // Illegal opcode.
      send(32'h0000_7000);
      chk("t6_err_opcode", 32'(err_opcode), 32'd1);
      chk("t6_illegal_not_busy", 32'(busy), 32'd0);
      chk("t6_illegal_count", 32'(done_count), 32'd2);

      // Reset during GAP.
      auto_done = 1'b1;
      done_lat  = 2;
      q_start.push_back(8'h03);
      offer(32'h0000_1103);
      repeat (4) tick();
      ARESETN = 1'b1;
      tick();
      chk_outputs_zero();
      ARESETN = 1'b0;
      repeat (20) tick();
      chk("t6_no_start_after_reset", 32'(dp_start), 32'd0);

      chk("final_start_queue_empty", 32'(q_start.size()), 32'd0);
      chk("final_abort_queue_empty", 32'(q_abort.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
